// File: rtl/fib_triple_gen.sv
// Emits a burst of Fibonacci triples (F(n), F(n+1), F(n+2)) with valid/ready, optionally corrupting odd triples.
// Latency: out_valid one cycle after start; one triple per cycle under constant ready; holds while !out_ready.
module fib_triple_gen #(
  parameter int WIDTH       = 4,
  parameter int NUM_TRIPLES = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode_bad,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic             expect_f,
  output logic [7:0]       idx,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

  localparam logic [WIDTH+1:0] MAX_VAL = {2'b00, {WIDTH{1'b1}}};
  localparam logic [7:0]       LAST_IDX = 8'(NUM_TRIPLES - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] x, y;
  logic [7:0]       idx_r;
  logic             bad_r;

  logic [WIDTH:0]   s;
  logic [WIDTH+1:0] nsum;
  logic             last, corrupt;

  assign s       = {1'b0, x} + {1'b0, y};
  assign nsum    = {2'b00, y} + {1'b0, s};
  assign last    = (idx_r == LAST_IDX);
  assign corrupt = bad_r && idx_r[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = EMIT;
      EMIT:    if (out_ready && last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Sequence wraps to (0,1) once the next triple's third term would not fit in WIDTH bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x     <= '0;
      y     <= WIDTH'(1);
      idx_r <= '0;
      bad_r <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          x     <= '0;
          y     <= WIDTH'(1);
          idx_r <= '0;
          bad_r <= mode_bad;
        end
        EMIT: if (out_ready) begin
          if (nsum > MAX_VAL) begin
            x <= '0;
            y <= WIDTH'(1);
          end else begin
            x <= y;
            y <= s[WIDTH-1:0];
          end
          if (!last) idx_r <= idx_r + 8'd1;
        end
        DONE: idx_r <= '0;
        default: ;
      endcase
    end
  end

  always_comb begin
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    a         = '0;
    b         = '0;
    c         = '0;
    expect_f  = 1'b0;
    idx       = idx_r;
    case (state)
      EMIT: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        a         = x;
        b         = y;
        c         = s[WIDTH-1:0] + WIDTH'(corrupt);
        expect_f  = !corrupt;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fib_triple_gen.sv
// Drives three generators (6, 9 and 1 triples per burst) from shared stimulus and checks each
// against a Fibonacci-number model every cycle, plus hand-computed literal expectations.
module tb_fib_triple_gen;

  localparam int W    = 4;
  localparam int MASK = (1 << W) - 1;
  localparam int NI   = 3;
  localparam int NUMS [NI] = '{6, 9, 1};

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic mode_bad = 1'b0;
  logic out_ready = 1'b1;

  logic         ov   [NI];
  logic [W-1:0] ao   [NI];
  logic [W-1:0] bo   [NI];
  logic [W-1:0] co   [NI];
  logic         efo  [NI];
  logic [7:0]   idxo [NI];
  logic         bsy  [NI];
  logic         dn   [NI];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fib_triple_gen #(.WIDTH(W), .NUM_TRIPLES(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode_bad(mode_bad), .out_ready(out_ready),
    .out_valid(ov[0]), .a(ao[0]), .b(bo[0]), .c(co[0]), .expect_f(efo[0]),
    .idx(idxo[0]), .busy(bsy[0]), .done(dn[0]));

  fib_triple_gen #(.WIDTH(W), .NUM_TRIPLES(9)) dut9 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode_bad(mode_bad), .out_ready(out_ready),
    .out_valid(ov[1]), .a(ao[1]), .b(bo[1]), .c(co[1]), .expect_f(efo[1]),
    .idx(idxo[1]), .busy(bsy[1]), .done(dn[1]));

  fib_triple_gen #(.WIDTH(W), .NUM_TRIPLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode_bad(mode_bad), .out_ready(out_ready),
    .out_valid(ov[2]), .a(ao[2]), .b(bo[2]), .c(co[2]), .expect_f(efo[2]),
    .idx(idxo[2]), .busy(bsy[2]), .done(dn[2]));

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int fib(input int n);
    int p = 0, q = 1, t;
    for (int i = 0; i < n; i++) begin
      t = p + q;
      p = q;
      q = t;
    end
    return p;
  endfunction

  // Number of distinct triples before the third term would exceed W bits.
  function automatic int period();
    int n = 0;
    while (fib(n + 2) <= MASK) n++;
    return n;
  endfunction

  function automatic int exp_a(input int k);
    return fib(k % period());
  endfunction

  function automatic int exp_b(input int k);
    return fib(k % period() + 1);
  endfunction

  function automatic int exp_c(input int k, input bit bad);
    int v = fib(k % period() + 2);
    if (bad && (k % 2 == 1)) v = (v + 1) & MASK;
    return v;
  endfunction

  // What the three-term Fibonacci checker reports for a triple.
  function automatic int fib3(input int x, input int y, input int z);
    return (x + y == z) ? 1 : 0;
  endfunction

  // Model state per instance: 0 idle, 1 emitting, 2 done.
  int ph  [NI] = '{0, 0, 0};
  int k   [NI] = '{0, 0, 0};
  bit bad [NI] = '{0, 0, 0};

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) begin
        ph[i] = 0;
        k[i]  = 0;
        chk($sformatf("rst_valid[%0d]", i), ov[i], 0);
        chk($sformatf("rst_busy[%0d]", i), bsy[i], 0);
        chk($sformatf("rst_done[%0d]", i), dn[i], 0);
      end else begin
        chk($sformatf("out_valid[%0d]", i), ov[i], (ph[i] == 1) ? 1 : 0);
        chk($sformatf("busy[%0d]", i), bsy[i], (ph[i] != 0) ? 1 : 0);
        chk($sformatf("done[%0d]", i), dn[i], (ph[i] == 2) ? 1 : 0);
        if (ph[i] == 0) chk($sformatf("idle_idx[%0d]", i), idxo[i], 0);
        if (ph[i] == 1) begin
          chk($sformatf("a[%0d]", i), ao[i], exp_a(k[i]));
          chk($sformatf("b[%0d]", i), bo[i], exp_b(k[i]));
          chk($sformatf("c[%0d]", i), co[i], exp_c(k[i], bad[i]));
          chk($sformatf("idx[%0d]", i), idxo[i], k[i]);
          chk($sformatf("expect_f[%0d]", i), efo[i],
              fib3(exp_a(k[i]), exp_b(k[i]), exp_c(k[i], bad[i])));
        end
        case (ph[i])
          0: if (start) begin ph[i] = 1; k[i] = 0; bad[i] = mode_bad; end
          1: if (out_ready) begin
            if (k[i] == NUMS[i] - 1) ph[i] = 2;
            else k[i]++;
          end
          default: ph[i] = 0;
        endcase
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_start(input bit bad_mode);
    start    = 1'b1;
    mode_bad = bad_mode;
    step();
    start = 1'b0;
  endtask

  task automatic chk_triple(input string name, input int ea, input int eb, input int ec, input int ei);
    chk({name, "_a"}, ao[0], ea);
    chk({name, "_b"}, bo[0], eb);
    chk({name, "_c"}, co[0], ec);
    chk({name, "_idx"}, idxo[0], ei);
  endtask

  initial begin
    // Pin the model against hand-derived values.
    chk("model_period", period(), 6);
    chk("model_c5", exp_c(5, 0), 13);
    chk("model_wrap_a6", exp_a(6), 0);
    chk("model_wrap_c8", exp_c(8, 0), 3);
    chk("model_bad_c3", exp_c(3, 1), 6);
    chk("model_bad_c5", exp_c(5, 1), 14);
    chk("model_bad_f1", fib3(exp_a(1), exp_b(1), exp_c(1, 1)), 0);

    #1 rst_n = 1'b0;
    #1;
    chk("reset_valid", ov[0], 0);
    chk_triple("reset", 0, 0, 0, 0);
    chk("reset_f", efo[0], 0);
    chk("reset_busy", bsy[0], 0);
    chk("reset_done", dn[0], 0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Clean burst, ready held high; start and ready both high in IDLE.
    pulse_start(1'b0);
    chk_triple("first", 0, 1, 1, 0);
    repeat (5) step();
    chk_triple("sixth", 5, 8, 13, 5);
    step();
    chk("done_pulse", dn[0], 1);
    step();
    chk("busy_fall", bsy[0], 0);
    repeat (6) step();

    // Backpressure while (1,2,3) is presented.
    pulse_start(1'b0);
    step();
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk_triple("hold", 1, 2, 3, 2);
      step();
    end
    out_ready = 1'b1;
    step();
    chk_triple("after_hold", 2, 3, 5, 3);
    repeat (16) step();

    // Corrupting burst; mode_bad changes mid-burst must not matter.
    pulse_start(1'b1);
    mode_bad = 1'b0;
    step();
    chk_triple("bad1", 1, 1, 3, 1);
    chk("bad1_f", efo[0], 0);
    mode_bad = 1'b1;
    repeat (14) step();
    mode_bad = 1'b0;

    // Asynchronous reset during triple idx=3.
    pulse_start(1'b0);
    repeat (3) step();
    chk_triple("pre_rst", 2, 3, 5, 3);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", ov[0], 0);
    chk_triple("arst", 0, 0, 0, 0);
    chk("arst_busy", bsy[0], 0);
    step();
    rst_n = 1'b1;
    step();
    pulse_start(1'b0);
    chk_triple("restart", 0, 1, 1, 0);
    repeat (14) step();

    // start pulses during EMIT and during DONE are ignored.
    pulse_start(1'b0);
    step();
    step();
    pulse_start(1'b1);
    repeat (3) step();
    chk("busy_done", dn[0], 1);
    pulse_start(1'b0);
    chk("no_restart", bsy[0], 0);
    repeat (16) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fib_triple_gen.md
Name: fib_triple_gen

Overview:
- Sequential stimulus source for the three-nibble Fibonacci checker (fibonacci3).
- Generates a burst of consecutive Fibonacci triples (F(n), F(n+1), F(n+2)) on three WIDTH-bit buses, with a valid/ready handshake.
- Can inject corrupted triples for negative testing, and drives expect_f with the checker output those triples should produce.

Parameters:
- WIDTH, 4, bit width of each of a, b, c.
- NUM_TRIPLES, 6, triples emitted per burst; legal range 1..255.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a burst; sampled only in IDLE.
- mode_bad  input  1  corruption enable; sampled together with start.
- out_ready  input  1  consumer ready.
- out_valid  output  1  triple on a/b/c is valid.
- a  output  WIDTH  first term, F(n).
- b  output  WIDTH  second term, F(n+1).
- c  output  WIDTH  third term, F(n+2) or corrupted value.
- expect_f  output  1  checker output expected for the current triple.
- idx  output  8  index of the current triple within the burst, 0-based.
- busy  output  1  burst in progress (EMIT or DONE).
- done  output  1  one-cycle pulse after the last triple is accepted.

Behaviour:
- Clock and reset:
  - One clock; reset is asynchronous and active-low (clk, rst_n).
  - Reset, at any time including mid-burst, immediately forces: state IDLE, out_valid=0, a=b=c=0, expect_f=0, idx=0, busy=0, done=0, internal x=0, y=1, bad_r=0.
- States: IDLE, EMIT, DONE.
- IDLE:
  - out_valid=0, busy=0.
  - On start=1: load x=0, y=1, idx=0, and bad_r=mode_bad; go to EMIT.
  - out_valid rises the following cycle (1-cycle latency from start).
- EMIT:
  - out_valid=1, busy=1.
  - a=x, b=y.
  - s=(x+y) computed at WIDTH+1 bits.
  - c=s[WIDTH-1:0], except when bad_r=1 and idx is odd: then c=(s+1) mod 2^WIDTH.
  - expect_f=1 for clean triples, 0 for corrupted ones.
  - Handshake: transfer occurs on a rising edge with out_valid&&out_ready.
  - a/b/c/expect_f/idx stay stable while out_valid&&!out_ready (no change, no drop).
- Advance, on each transfer:
  - Next sum: x+2y = y+s.
  - If next sum > 2^WIDTH-1 (overflow at WIDTH+1 bits): wrap to x=0, y=1.
  - Otherwise: x<=y, y<=s.
  - idx<=idx+1.
  - For WIDTH=4 the clean sequence is: (0,1,1), (1,1,2), (1,2,3), (2,3,5), (3,5,8), (5,8,13), then wrap to (0,1,1).
  - If idx==NUM_TRIPLES-1 at transfer: go to DONE instead of advancing idx.
- DONE:
  - Lasts exactly one cycle.
  - out_valid=0, done=1, busy=1.
  - Next state IDLE; idx returns to 0.
- Boundary rules:
  - start while in EMIT or DONE is ignored.
  - start and out_ready both high in IDLE: only start acts.
  - mode_bad changes mid-burst have no effect.
  - NUM_TRIPLES=1: one triple (0,1,1), then DONE.
  - out_ready may be held high permanently, giving one triple per cycle.
  - out_valid never deasserts inside EMIT except via reset.
- Implementation constraints:
  - All outputs are registered or decoded from registered state only; there is no combinational path from out_ready to out_valid/a/b/c.
  - No latches.

Test Plan:
- Reset, then start=1 for one cycle with mode_bad=0 and out_ready=1 held:
  - out_valid rises 1 cycle after start.
  - Six consecutive triples appear: (0,1,1), (1,1,2), (1,2,3), (2,3,5), (3,5,8), (5,8,13), each with expect_f=1.
  - done pulses one cycle after (5,8,13) is accepted; busy falls the cycle after that.
- NUM_TRIPLES=9, clean run:
  - Triples 6..8 are (0,1,1), (1,1,2), (1,2,3), confirming wrap after (5,8,13).
  - idx counts 0..8.
- Backpressure:
  - out_ready=0 for 5 cycles while (1,2,3) is presented: a/b/c/idx held at 1,2,3,2 the whole time.
  - The next accepted triple is (2,3,5); no skip, no duplicate.
- mode_bad=1 at start:
  - Triples are (0,1,1,f=1), (1,1,3,f=0), (1,2,3,f=1), (2,3,6,f=0), (3,5,8,f=1), (5,8,14,f=0).
  - Feeding each into fibonacci3 gives f equal to expect_f.
- rst_n pulsed low asynchronously (mid-cycle, off the clock edge) during triple idx=3:
  - Outputs clear immediately to their reset values.
  - A new start restarts the burst at (0,1,1).
- start pulsed while busy=1 (during EMIT and during the DONE cycle):
  - No restart; the sequence and done timing are unchanged.
